div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter DIV_LAT, default 32, cycles from div_data_rdy to div_res_rdy of the pipelined divider.
REQ-003 SHALL have parameter WDOG, default 40, max cycles waited for div_res_rdy before flagging error.
REQ-004 SHALL have port clk  input  1  single clock, all logic posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_valid/req_ready  input/output  1/1  request handshake from EX stage.
REQ-007 SHALL have ports req_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; req_rs1, req_rs2  input  XLEN; req_rd  input  5.
REQ-008 SHALL have port flush  input  1  kill the in-flight op.
REQ-009 SHALL have ports div_data_rdy  output  1; div_dividend, div_divisor  output  XLEN  (unsigned magnitudes to divider).
REQ-010 SHALL have ports div_res_rdy  input  1; div_merchant, div_remainder  input  XLEN  (divider results).
REQ-011 SHALL have ports resp_valid  output  1; resp_ready  input  1; resp_data  output  XLEN; resp_rd  output  5.
REQ-012 SHALL have ports busy  output  1 (state != IDLE); wdog_err  output  1 (sticky).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DRAIN, RESP.
REQ-014 SHALL assert req_ready only in IDLE with flush low; accept on req_valid && req_ready.
REQ-015 SHALL, for DIV/REM, convert rs1/rs2 to two's-complement magnitudes (0x80000000 maps to 0x80000000); DIVU/REMU pass unchanged.
REQ-016 SHALL latch op, rd, sign of rs1, sign of rs1 XOR rs2, and rs1 at accept.
REQ-017 SHALL take fast path when rs2==0: DIV/DIVU result 0xFFFFFFFF, REM/REMU result rs1; IDLE->RESP, no div_data_rdy.
REQ-018 SHALL take fast path for DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: DIV 0x80000000, REM 0.
REQ-019 SHALL otherwise go IDLE->WAIT and drive div_data_rdy high for exactly one cycle (T+1 for accept in cycle T), div_dividend/div_divisor stable that cycle.
REQ-020 SHALL, in WAIT on div_res_rdy (nominally T+1+DIV_LAT), capture result, go to RESP; resp_valid from next cycle.
REQ-021 SHALL fix signs: DIV quotient negated if signs differ; REM remainder negated if rs1 negative; unsigned ops unchanged.
REQ-022 SHALL select merchant for DIV/DIVU, remainder for REM/REMU.
REQ-023 SHALL hold resp_valid, resp_data, resp_rd stable in RESP until resp_ready; RESP->IDLE on resp_valid && resp_ready.
REQ-024 SHALL on flush: WAIT->DRAIN; RESP->IDLE with response dropped; IDLE no effect, no request accepted that cycle.
REQ-025 SHALL in DRAIN discard div_res_rdy result, go DRAIN->IDLE, never assert resp_valid.
REQ-026 SHALL ignore div_res_rdy in IDLE and RESP.
REQ-027 SHALL count cycles in WAIT/DRAIN; at WDOG without div_res_rdy set wdog_err and return to IDLE.
REQ-028 SHALL give flush priority over div_res_rdy in the same WAIT cycle (result discarded, go IDLE).

Reset
REQ-029 SHALL on rst: state IDLE; req_ready, div_data_rdy, resp_valid, busy, wdog_err = 0; data outputs 0; counter 0.
REQ-030 SHALL discard any in-flight op on rst; divider reset by same rst (inverted at top), no stale result after reset.

Structure
REQ-031 SHALL put op encodings, FSM state enum, DIV_LAT and WDOG defaults in shared package div_pkg.
REQ-032 SHALL implement sign fix/result select (REQ-021/022) as one combinational sub-module div_sign_fix.
REQ-033 SHALL be 120-400 RTL lines, one outstanding op, no internal FIFO.

Verification
REQ-034 SHALL cover DIVU 29/5 -> div_data_rdy at T+1, resp 5 at T+2+DIV_LAT; REMU -> 4.
REQ-035 SHALL cover DIV 0xFFFFFFF9/2 -> divider sees 7,2; resp 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-036 SHALL cover DIV 0x1234/0 -> resp 0xFFFFFFFF at T+1, no div_data_rdy; REM -> 0x1234.
REQ-037 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0.
REQ-038 SHALL cover flush at T+10 -> DRAIN, no resp_valid, req_ready returns after div_res_rdy.
REQ-039 SHALL cover resp_ready low 5 cycles -> resp held stable, req_ready 0; then handshake, IDLE.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Package     : div_pkg
// Description : Shared operation encodings, FSM state type, default timing
//               parameters and small decode helpers for the divider
//               controller slice.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default pipelined-divider latency and watchdog limit (cycles)
    localparam int c_div_lat_dflt = 32;
    localparam int c_wdog_dflt    = 40;

    // req_op encodings
    localparam logic [1:0] c_op_div  = 2'b00;
    localparam logic [1:0] c_op_divu = 2'b01;
    localparam logic [1:0] c_op_rem  = 2'b10;
    localparam logic [1:0] c_op_remu = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Signed operations need magnitude conversion and sign fix-up
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == c_op_div) || (op == c_op_rem);
    endfunction

    // Remainder operations return the remainder instead of the quotient
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == c_op_rem) || (op == c_op_remu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : div_ctrl_if
// Description : Bundles the EX-stage request/response handshakes and the
//               pipelined-divider launch/result signals of div_ctrl.
//               slave  = view of the controller itself
//               master = view of the surrounding pipeline and divider
// Revision    : 1.0 - initial release
// ============================================================================
interface div_ctrl_if #(
    parameter int XLEN = 32
);
    // request from EX stage
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [4:0]      req_rd;
    logic            flush;

    // divider launch and result
    logic            div_data_rdy;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic            div_res_rdy;
    logic [XLEN-1:0] div_merchant;
    logic [XLEN-1:0] div_remainder;

    // response towards writeback
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, flush,
        input  div_res_rdy, div_merchant, div_remainder,
        input  resp_ready,
        output req_ready,
        output div_data_rdy, div_dividend, div_divisor,
        output resp_valid, resp_data, resp_rd
    );

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, flush,
        output div_res_rdy, div_merchant, div_remainder,
        output resp_ready,
        input  req_ready,
        input  div_data_rdy, div_dividend, div_divisor,
        input  resp_valid, resp_data, resp_rd
    );

endinterface
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_fix
// Description : Combinational post-processing of the unsigned divider result:
//               picks quotient or remainder and restores the sign of signed
//               operations (quotient negative when operand signs differ,
//               remainder takes the sign of the dividend).
// Revision    : 1.0 - initial release
// ============================================================================
module div_sign_fix
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_op,
    input  logic            i_neg_quot,
    input  logic            i_neg_rem,
    input  logic [XLEN-1:0] i_merchant,
    input  logic [XLEN-1:0] i_remainder,
    output logic [XLEN-1:0] o_result
);

    logic w_signed;

    // Select the requested result and negate it when the signed case needs it
    always_comb begin
        w_signed = op_is_signed(i_op);
        if (op_is_rem(i_op)) begin
            o_result = (w_signed && i_neg_rem) ? -i_remainder : i_remainder;
        end else begin
            o_result = (w_signed && i_neg_quot) ? -i_merchant : i_merchant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Controller between the EX stage and an external pipelined
//               unsigned divider. Accepts one DIV/DIVU/REM/REMU at a time,
//               short-circuits divide-by-zero and signed overflow, launches
//               the divider with operand magnitudes otherwise, waits for the
//               result under a watchdog, fixes signs and returns the result
//               through a valid/ready response. Flush kills the in-flight op;
//               a divider result already in the pipe is drained and dropped.
//               The external divider shares rst, so no stale result can
//               arrive after a reset.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
    import div_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DIV_LAT = c_div_lat_dflt,
    parameter int WDOG    = c_wdog_dflt
) (
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave bus,
    output logic      busy,
    output logic      wdog_err
);

    // Counter must hold the watchdog limit and never wrap before the divider
    // could nominally answer.
    localparam int              c_cnt_max   = (WDOG > DIV_LAT) ? WDOG : DIV_LAT;
    localparam int              c_cw        = $clog2(c_cnt_max + 1);
    localparam logic [c_cw-1:0] c_wdog_last = c_cw'(WDOG - 1);
    localparam logic [XLEN-1:0] c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic            r_wdog_err;

    logic [1:0]      r_op;
    logic [4:0]      r_rd;
    logic            r_neg_quot;
    logic            r_neg_rem;

    logic            r_div_data_rdy;
    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_resp_data;
    logic [4:0]      r_resp_rd;

    logic            w_req_ready;
    logic            w_accept;
    logic            w_signed;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_data;
    logic [XLEN-1:0] w_fix_data;
    logic            w_capture;
    logic            w_wdog_hit;
    logic            w_cnt_run;

    // Request decode: accept condition, operand magnitudes and fast paths
    always_comb begin
        w_req_ready = !rst && (r_state == ST_IDLE) && !bus.flush;
        w_accept    = bus.req_valid && w_req_ready;
        w_signed    = op_is_signed(bus.req_op);
        w_rs1_neg   = w_signed && bus.req_rs1[XLEN-1];
        w_rs2_neg   = w_signed && bus.req_rs2[XLEN-1];
        // most negative value maps onto itself, which is its true magnitude
        w_mag1      = w_rs1_neg ? -bus.req_rs1 : bus.req_rs1;
        w_mag2      = w_rs2_neg ? -bus.req_rs2 : bus.req_rs2;
        w_div_zero  = (bus.req_rs2 == '0);
        w_ovf       = w_signed && (bus.req_rs1 == c_int_min) && (bus.req_rs2 == '1);
        w_fast      = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_fast_data = op_is_rem(bus.req_op) ? bus.req_rs1 : '1;
        end else begin
            w_fast_data = op_is_rem(bus.req_op) ? '0 : c_int_min;
        end
    end

    div_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .i_op        (r_op),
        .i_neg_quot  (r_neg_quot),
        .i_neg_rem   (r_neg_rem),
        .i_merchant  (bus.div_merchant),
        .i_remainder (bus.div_remainder),
        .o_result    (w_fix_data)
    );

    // Next-state logic; flush outranks a same-cycle divider result
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_wdog_hit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.flush) begin
                    w_state_nxt = bus.div_res_rdy ? ST_IDLE : ST_DRAIN;
                end else if (bus.div_res_rdy) begin
                    w_state_nxt = ST_RESP;
                    w_capture   = 1'b1;
                end else if (r_cnt >= c_wdog_last) begin
                    w_state_nxt = ST_IDLE;
                    w_wdog_hit  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.div_res_rdy) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt >= c_wdog_last) begin
                    w_state_nxt = ST_IDLE;
                    w_wdog_hit  = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.flush || bus.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_cnt_run = ((r_state == ST_WAIT) || (r_state == ST_DRAIN)) &&
                    ((w_state_nxt == ST_WAIT) || (w_state_nxt == ST_DRAIN));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operation context, one-cycle divider launch and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op           <= '0;
            r_rd           <= '0;
            r_neg_quot     <= 1'b0;
            r_neg_rem      <= 1'b0;
            r_div_data_rdy <= 1'b0;
            r_dividend     <= '0;
            r_divisor      <= '0;
            r_resp_data    <= '0;
            r_resp_rd      <= '0;
        end else begin
            r_div_data_rdy <= 1'b0;
            if (w_accept) begin
                r_op       <= bus.req_op;
                r_rd       <= bus.req_rd;
                r_neg_rem  <= w_rs1_neg;
                r_neg_quot <= w_rs1_neg ^ w_rs2_neg;
                if (w_fast) begin
                    r_resp_data <= w_fast_data;
                    r_resp_rd   <= bus.req_rd;
                end else begin
                    r_div_data_rdy <= 1'b1;
                    r_dividend     <= w_mag1;
                    r_divisor      <= w_mag2;
                end
            end
            if (w_capture) begin
                r_resp_data <= w_fix_data;
                r_resp_rd   <= r_rd;
            end
        end
    end

    // Watchdog: cycles spent waiting on the divider, sticky error on expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_run ? (r_cnt + 1'b1) : '0;
            r_wdog_err <= r_wdog_err | w_wdog_hit;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.div_data_rdy = r_div_data_rdy;
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.resp_valid   = (r_state == ST_RESP);
    assign bus.resp_data    = r_resp_data;
    assign bus.resp_rd      = r_resp_rd;
    assign busy             = (r_state != ST_IDLE);
    assign wdog_err         = r_wdog_err;

endmodule
`default_nettype wire
